// File: rtl/line_pkg.sv
// Shared definitions for the object-layer drawers: transparency code,
// the signed pixel-coordinate type and a saturating absolute value.
package line_pkg;

  localparam int unsigned LINE_COORD_W = 11;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  typedef logic signed [LINE_COORD_W-1:0] coord_t;

  // |v|, clamped so the most negative value cannot wrap back to negative.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] v);
    if (v == 32'sh8000_0000) begin
      return 32'h7FFF_FFFF;
    end else if (v < 0) begin
      return 32'(-v);
    end else begin
      return 32'(v);
    end
  endfunction

endpackage

// File: rtl/line_shadow_regs.sv
// Frame-synchronous shadow copy of the aiming-line geometry and modes.
// Everything is captured on startOfFrame so the line never tears mid-frame.
module line_shadow_regs
  import line_pkg::*;
#(
  parameter int COORD_W      = 11,
  parameter int BALL_RADIUS  = 16,
  parameter int MAX_LEN      = 256,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      sof_i,
  input  logic signed [COORD_W-1:0] tl_x_i,
  input  logic signed [COORD_W-1:0] tl_y_i,
  input  logic signed [COORD_W-1:0] vel_x_i,
  input  logic signed [COORD_W-1:0] vel_y_i,
  input  logic                      en_i,
  input  logic                      dash_i,
  input  logic                      blink_i,
  output logic signed [COORD_W+1:0] cx_o,
  output logic signed [COORD_W+1:0] cy_o,
  output logic signed [COORD_W+1:0] ex_o,
  output logic signed [COORD_W+1:0] ey_o,
  output logic signed [COORD_W-1:0] vx_o,
  output logic signed [COORD_W-1:0] vy_o,
  output logic                      major_o,
  output logic                      en_o,
  output logic                      dash_o,
  output logic                      blink_o,
  output logic                      blink_on_o
);

  // Positions get two guard bits: centre and end point may leave the
  // COORD_W range once the radius and velocity are added.
  localparam int CW    = COORD_W + 2;
  localparam int CNT_W = $clog2(2 * BLINK_FRAMES);

  logic signed [CW-1:0]      cx_d, cy_d, ex_d, ey_d;
  logic signed [CW-1:0]      cx_q, cy_q, ex_q, ey_q;
  logic signed [COORD_W-1:0] vx_d, vy_d, vx_q, vy_q;
  logic                      major_d, major_q;
  logic                      en_q, dash_q, blink_q, blink_on_q;
  logic                      blink_on_d;
  logic [CNT_W-1:0]          cnt_d, cnt_q;

  // Clamp one velocity component to [-MAX_LEN, MAX_LEN].
  function automatic logic signed [COORD_W-1:0] sat_vel(input logic signed [COORD_W-1:0] v);
    logic signed [31:0] w;
    w = 32'(v);
    if (w > MAX_LEN) begin
      return COORD_W'(MAX_LEN);
    end else if (w < -MAX_LEN) begin
      return COORD_W'(-MAX_LEN);
    end else begin
      return v;
    end
  endfunction

  // Geometry to be captured at the next startOfFrame.
  always_comb begin
    vx_d       = sat_vel(vel_x_i);
    vy_d       = sat_vel(vel_y_i);
    cx_d       = CW'(tl_x_i) + CW'(BALL_RADIUS);
    cy_d       = CW'(tl_y_i) + CW'(BALL_RADIUS);
    ex_d       = cx_d + CW'(vx_d);
    ey_d       = cy_d + CW'(vy_d);
    major_d    = sat_abs(32'(vx_d)) >= sat_abs(32'(vy_d));
    // The phase for the new frame follows the count before it advances,
    // so the first frame after reset is frame 0 and visible.
    blink_on_d = cnt_q < CNT_W'(BLINK_FRAMES);
    if (cnt_q == CNT_W'(2 * BLINK_FRAMES - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Geometry shadow; gated by en_q downstream, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (sof_i) begin
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      major_q <= major_d;
    end
  end

  // Mode latches and blink frame counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q       <= 1'b0;
      dash_q     <= 1'b0;
      blink_q    <= 1'b0;
      blink_on_q <= 1'b0;
      cnt_q      <= '0;
    end else if (sof_i) begin
      en_q       <= en_i;
      dash_q     <= dash_i;
      blink_q    <= blink_i;
      blink_on_q <= blink_on_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cx_o       = cx_q;
  assign cy_o       = cy_q;
  assign ex_o       = ex_q;
  assign ey_o       = ey_q;
  assign vx_o       = vx_q;
  assign vy_o       = vy_q;
  assign major_o    = major_q;
  assign en_o       = en_q;
  assign dash_o     = dash_q;
  assign blink_o    = blink_q;
  assign blink_on_o = blink_on_q;

endmodule

// File: rtl/aim_line_draw.sv
// Cue aiming-line drawer: a thick segment from the ball centre along the
// latched velocity, with optional dashes and blinking. Three-stage pixel
// pipeline, one result per clock.
module aim_line_draw
  import line_pkg::*;
#(
  parameter int         COORD_W        = 11,
  parameter int         BALL_RADIUS    = 16,
  parameter int         LINE_THICKNESS = 80,
  parameter int         MAX_LEN        = 256,
  parameter int         DASH_LEN       = 8,
  parameter int         BLINK_FRAMES   = 16,
  parameter logic [7:0] LINE_COLOR     = 8'h03
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      startOfFrame,
  input  logic signed [COORD_W-1:0] pixelX,
  input  logic signed [COORD_W-1:0] pixelY,
  input  logic signed [COORD_W-1:0] lineTopLeftPosX,
  input  logic signed [COORD_W-1:0] lineTopLeftPosY,
  input  logic signed [COORD_W-1:0] velocityX,
  input  logic signed [COORD_W-1:0] velocityY,
  input  logic                      lineEnable,
  input  logic                      dashMode,
  input  logic                      blinkMode,
  output logic                      drawingRequestLine,
  output logic [7:0]                RGBoutLine
);

  localparam int CW  = COORD_W + 2;
  localparam int CRW = 2 * COORD_W + 2;

  logic signed [CW-1:0]      cx, cy, ex, ey;
  logic signed [COORD_W-1:0] vx, vy;
  logic                      major, en, dash, blink, blink_on;

  line_shadow_regs #(
    .COORD_W      (COORD_W),
    .BALL_RADIUS  (BALL_RADIUS),
    .MAX_LEN      (MAX_LEN),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_shadow (
    .clk_i      (clk),
    .rst_i      (reset),
    .sof_i      (startOfFrame),
    .tl_x_i     (lineTopLeftPosX),
    .tl_y_i     (lineTopLeftPosY),
    .vel_x_i    (velocityX),
    .vel_y_i    (velocityY),
    .en_i       (lineEnable),
    .dash_i     (dashMode),
    .blink_i    (blinkMode),
    .cx_o       (cx),
    .cy_o       (cy),
    .ex_o       (ex),
    .ey_o       (ey),
    .vx_o       (vx),
    .vy_o       (vy),
    .major_o    (major),
    .en_o       (en),
    .dash_o     (dash),
    .blink_o    (blink),
    .blink_on_o (blink_on)
  );

  logic signed [CW-1:0]      px_w, py_w, dx_d, dy_d;
  logic                      inbox_d, gate_d;

  logic signed [CW-1:0]      dx_p0, dy_p0;
  logic signed [COORD_W-1:0] vx_p0, vy_p0;
  logic                      major_p0, dash_p0, inbox_p0, gate_p0, vld_p0;

  logic signed [CRW-1:0]     cross_d;
  logic signed [CW-1:0]      t_w;
  logic                      dash_ok_d;

  logic signed [CRW-1:0]     cross_p1;
  logic                      dash_ok_p1, inbox_p1, gate_p1, vld_p1;

  logic                      hit_d, draw_p2;

  // ---- stage 0: offsets from centre, bounding box, frame-level gates ----
  always_comb begin
    px_w    = CW'(pixelX);
    py_w    = CW'(pixelY);
    dx_d    = px_w - cx;
    dy_d    = py_w - cy;
    inbox_d = ((px_w >= cx && px_w <= ex) || (px_w >= ex && px_w <= cx)) &&
              ((py_w >= cy && py_w <= ey) || (py_w >= ey && py_w <= cy));
    gate_d  = en && (vx != '0 || vy != '0) && (!blink || blink_on);
  end

  // Stage 0 data, carrying the vector with the pixel so a relatch
  // never mixes two frames' geometry inside the pipe.
  always_ff @(posedge clk) begin
    dx_p0    <= dx_d;
    dy_p0    <= dy_d;
    vx_p0    <= vx;
    vy_p0    <= vy;
    major_p0 <= major;
    dash_p0  <= dash;
    inbox_p0 <= inbox_d;
    gate_p0  <= gate_d;
  end

  // ---- stage 1: cross product and dash phase ----
  always_comb begin
    cross_d   = CRW'(vy_p0) * CRW'(dx_p0) - CRW'(vx_p0) * CRW'(dy_p0);
    t_w       = major_p0 ? ((dx_p0 < 0) ? -dx_p0 : dx_p0)
                         : ((dy_p0 < 0) ? -dy_p0 : dy_p0);
    // DASH_LEN is a power of two, so masking with it selects the dash bit.
    dash_ok_d = !dash_p0 || ((t_w & CW'(DASH_LEN)) == '0);
  end

  // Stage 1 data.
  always_ff @(posedge clk) begin
    cross_p1   <= cross_d;
    dash_ok_p1 <= dash_ok_d;
    inbox_p1   <= inbox_p0;
    gate_p1    <= gate_p0;
  end

  // ---- stage 2: thickness test and final decision ----
  always_comb begin
    hit_d = vld_p1 && gate_p1 && inbox_p1 && dash_ok_p1 &&
            (sat_abs(32'(cross_p1)) <= 32'(LINE_THICKNESS));
  end

  // Valid bits and the registered draw flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      draw_p2 <= 1'b0;
    end else begin
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      draw_p2 <= hit_d;
    end
  end

  assign drawingRequestLine = draw_p2;
  assign RGBoutLine         = draw_p2 ? LINE_COLOR : TRANSPARENT_ENCODING;

endmodule

// File: tb/tb_aim_line_draw.sv
// Directed bench for aim_line_draw with hand-computed pixel expectations.
module tb_aim_line_draw;
  import line_pkg::*;

  logic   clk;
  logic   reset;
  logic   startOfFrame;
  coord_t pixelX, pixelY;
  coord_t lineTopLeftPosX, lineTopLeftPosY;
  coord_t velocityX, velocityY;
  logic   lineEnable, dashMode, blinkMode;
  logic   drawingRequestLine;
  logic [7:0] RGBoutLine;

  int vectors     = 0;
  int miscompares = 0;

  aim_line_draw dut (
    .clk                (clk),
    .reset              (reset),
    .startOfFrame       (startOfFrame),
    .pixelX             (pixelX),
    .pixelY             (pixelY),
    .lineTopLeftPosX    (lineTopLeftPosX),
    .lineTopLeftPosY    (lineTopLeftPosY),
    .velocityX          (velocityX),
    .velocityY          (velocityY),
    .lineEnable         (lineEnable),
    .dashMode           (dashMode),
    .blinkMode          (blinkMode),
    .drawingRequestLine (drawingRequestLine),
    .RGBoutLine         (RGBoutLine)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_pix(input int x, input int y);
    @(negedge clk);
    pixelX = 11'(x);
    pixelY = 11'(y);
  endtask

  // Present a pixel and check the result after the 3-cycle latency.
  task automatic probe(input string tag, input int x, input int y, input bit exp);
    set_pix(x, y);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_req"}, 32'(drawingRequestLine), 32'(exp));
    chk({tag, "_rgb"}, 32'(RGBoutLine), exp ? 32'h03 : 32'hFF);
  endtask

  task automatic frame(input int vx, input int vy, input bit en, input bit dsh, input bit blk);
    @(negedge clk);
    velocityX    = 11'(vx);
    velocityY    = 11'(vy);
    lineEnable   = en;
    dashMode     = dsh;
    blinkMode    = blk;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    startOfFrame    = 1'b0;
    pixelX          = '0;
    pixelY          = '0;
    lineTopLeftPosX = 11'sd100;
    lineTopLeftPosY = 11'sd100;
    velocityX       = 11'sd40;
    velocityY       = '0;
    lineEnable      = 1'b1;
    dashMode        = 1'b0;
    blinkMode       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(drawingRequestLine), 32'd0);
    chk("rst_rgb", 32'(RGBoutLine), 32'hFF);
    @(negedge clk);
    reset = 1'b0;
    probe("no_sof", 120, 116, 1'b0);

    // Horizontal line from (116,116) to (156,116).
    frame(40, 0, 1, 0, 0);
    probe("h_start", 116, 116, 1'b1);
    probe("h_mid",   136, 116, 1'b1);
    probe("h_end",   156, 116, 1'b1);
    probe("h_past",  157, 116, 1'b0);
    probe("h_before", 115, 116, 1'b0);

    // Latency: output switches on the third edge after the pixel.
    set_pix(0, 0);
    repeat (4) @(posedge clk);
    set_pix(120, 116);
    repeat (2) @(posedge clk);
    #1;
    chk("lat_2", 32'(drawingRequestLine), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_3", 32'(drawingRequestLine), 32'd1);

    // Diagonal thickness.
    frame(30, 30, 1, 0, 0);
    probe("diag_on",  126, 126, 1'b1);
    probe("diag_off", 126, 129, 1'b0);

    // Saturation to 256 and zero vector.
    frame(600, 0, 1, 0, 0);
    probe("sat_last", 372, 116, 1'b1);
    probe("sat_past", 373, 116, 1'b0);
    frame(0, 0, 1, 0, 0);
    probe("zero_ctr", 116, 116, 1'b0);

    // Dashed rendering: 8 on, 8 off along X.
    frame(40, 0, 1, 1, 0);
    probe("dash_t0",  116, 116, 1'b1);
    probe("dash_t7",  123, 116, 1'b1);
    probe("dash_t8",  124, 116, 1'b0);
    probe("dash_t15", 131, 116, 1'b0);
    probe("dash_t16", 132, 116, 1'b1);
    probe("dash_t23", 139, 116, 1'b1);

    // Mid-frame velocity change is ignored until the next startOfFrame.
    frame(40, 0, 1, 0, 0);
    @(negedge clk);
    velocityX = 11'sd10;
    probe("latch_hold", 150, 116, 1'b1);
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    probe("latch_new_out", 150, 116, 1'b0);
    probe("latch_new_in",  126, 116, 1'b1);

    // Reset asserted while the line is being drawn.
    frame(40, 0, 1, 0, 0);
    set_pix(120, 116);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_req", 32'(drawingRequestLine), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_req", 32'(drawingRequestLine), 32'd0);
    chk("async_rst_rgb", 32'(RGBoutLine), 32'hFF);
    @(negedge clk);
    reset = 1'b0;
    probe("post_rst", 120, 116, 1'b0);
    frame(40, 0, 1, 0, 0);
    probe("post_rst_sof", 120, 116, 1'b1);

    // Blink: frames 0..15 on, 16..31 off, 32 on again.
    do_reset();
    for (int k = 0; k <= 32; k++) begin
      frame(40, 0, 1, 0, 1);
      probe($sformatf("blink_f%0d", k), 120, 116, (k < 16) || (k >= 32));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
